// File: rtl/ap_pkg.sv
// Shared types and defaults for the 16-bit accumulator processor.
package ap_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory (req/ack), hands words to the IR.
// Optional FETCH_COUNT_EN adds o_fetch_count, a wrapping count of accepted instructions.
module inst_fetch_unit
  import ap_pkg::*;
#(
  parameter int unsigned         ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [INST_W-1:0] i_mem_rdata,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       o_fetch_count
`endif
);

  fetch_state_t      r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid, w_valid_next;
  logic              w_load_inst;
  logic              w_accept;

  // The IR handshake counts even when a redirect lands in the same cycle.
  assign w_accept = (r_state == HOLD) && r_inst_valid && i_inst_ready;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_inst_valid;
    w_load_inst  = 1'b0;
    unique case (r_state)
      IDLE: w_state_next = FETCH;
      FETCH: begin
        if (i_mem_ack) begin
          w_load_inst  = 1'b1;
          w_valid_next = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_accept) begin
          w_pc_next    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_valid_next = 1'b0;
          w_state_next = FETCH;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Redirect discards any ack arriving in the same cycle.
    if (i_redirect) begin
      w_pc_next    = i_redirect_pc;
      w_valid_next = 1'b0;
      w_load_inst  = 1'b0;
      w_state_next = FETCH;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_inst_valid <= w_valid_next;
      if (w_load_inst) begin
        r_inst    <= i_mem_rdata;
        r_inst_pc <= r_pc;
      end
    end
  end

  assign o_mem_req    = (r_state == FETCH);
  assign o_mem_addr   = r_pc;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_valid = r_inst_valid;

`ifdef FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  // No handshake counter in this build.
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: memory model with programmable ack delay and a
// scoreboard of fetched words; FETCH_COUNT_EN also checks o_fetch_count.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic [15:0] o_inst;
  logic [15:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
`ifdef FETCH_COUNT_EN
  logic [15:0] o_fetch_count;
`endif

  inst_fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .o_inst_valid (o_inst_valid),
    .i_inst_ready (i_inst_ready),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc)
`ifdef FETCH_COUNT_EN
    ,
    .o_fetch_count(o_fetch_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] sb_q[$];  // {pc, inst}
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] exp_count = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h8123;
      16'h0001: return 16'h4ABC;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // One clock: predict from inputs about to be sampled, step, check new instructions, drive memory.
  task automatic cycle();
    logic [31:0] exp;
    if (!i_rst && i_mem_ack && o_mem_req && !i_redirect) sb_q.push_back({o_mem_addr, i_mem_rdata});
    if (i_rst) exp_count = '0;
    else if (o_inst_valid && i_inst_ready) exp_count = exp_count + 16'd1;
    @(posedge clk);
    #1;
    cyc++;
    if (o_inst_valid && !prev_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction",
                 o_inst_pc, o_inst);
      end else begin
        exp = sb_q.pop_front();
        if ({o_inst_pc, o_inst} !== exp) begin
          bad++;
          $display("FAIL sb_inst: got pc=%h inst=%h, required pc=%h inst=%h",
                   o_inst_pc, o_inst, exp[31:16], exp[15:0]);
        end
      end
    end
    prev_valid = o_inst_valid;
    if (i_mem_ack) wait_cnt = 0;
    i_mem_ack = 1'b0;
    if (!i_rst && o_mem_req) begin
      if (wait_cnt >= ack_delay) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem_word(o_mem_addr);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_inst_valid && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (!o_inst_valid) begin
      bad++;
      $display("FAIL %s_timeout: inst_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_inst_ready = 1'b1;
    cycle();
    cycle();
    total++;
    if ({o_mem_req, o_inst_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctl: got req=%b valid=%b, required 0 0", o_mem_req, o_inst_valid);
    end
    total++;
    if ({o_inst, o_inst_pc, o_mem_addr} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: got inst=%h pc=%h addr=%h, required 0 0 0",
               o_inst, o_inst_pc, o_mem_addr);
    end
`ifdef FETCH_COUNT_EN
    total++;
    if (o_fetch_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d, required 0", o_fetch_count);
    end
`endif
    i_rst = 1'b0;
    cycle();
    total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h, required 1 0000", o_mem_req, o_mem_addr);
    end
  endtask

  task automatic test_stream();
    int t[2];
    int n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      cycle();
      if (o_inst_valid) begin
        t[n] = cyc;
        n++;
      end
    end
    total++;
    if (n != 2 || t[1] - t[0] != 2) begin
      bad++;
      $display("FAIL stream_rate: got %0d instructions spacing %0d, required 2 spacing 2",
               n, (n == 2) ? t[1] - t[0] : -1);
    end
    cycle();
`ifdef FETCH_COUNT_EN
    total++;
    if (o_fetch_count !== 16'd2) begin
      bad++;
      $display("FAIL stream_count: got %0d, required 2", o_fetch_count);
    end
`endif
  endtask

  task automatic test_hold();
    logic [15:0] held_inst, held_pc, exp_a;
    i_inst_ready = 1'b0;
    wait_valid("hold");
    held_inst = o_inst;
    held_pc = o_inst_pc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++;
      if (o_inst_valid !== 1'b1 || o_inst !== held_inst || o_mem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: got valid=%b inst=%h req=%b, required 1 %h 0",
                 o_inst_valid, o_inst, o_mem_req, held_inst);
      end
    end
    exp_a = held_pc + 16'd1;
    i_inst_ready = 1'b1;
    cycle();
    total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== exp_a || o_inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_accept: got req=%b addr=%h valid=%b, required 1 %h 0",
               o_mem_req, o_mem_addr, o_inst_valid, exp_a);
    end
    i_inst_ready = 1'b0;
    wait_valid("hold_next");
  endtask

  task automatic test_delay();
    logic [15:0] rec;
    int req_cycles = 0;
    ack_delay = 3;
    i_inst_ready = 1'b1;
    cycle();
    i_inst_ready = 1'b0;
    rec = o_mem_addr;
    for (int i = 0; i < 20 && !o_inst_valid; i++) begin
      total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== rec) begin
        bad++;
        $display("FAIL delay_req: got req=%b addr=%h, required 1 %h", o_mem_req, o_mem_addr, rec);
      end
      req_cycles++;
      cycle();
    end
    total++;
    if (!o_inst_valid || req_cycles != 4) begin
      bad++;
      $display("FAIL delay_latency: got valid=%b after %0d req cycles, required 1 after 4",
               o_inst_valid, req_cycles);
    end
    ack_delay = 0;
  endtask

  task automatic test_redirect_ack();
    i_inst_ready = 1'b1;
    cycle();
    i_inst_ready = 1'b0;
    i_redirect = 1'b1;
    i_redirect_pc = 16'h0040;
    cycle();
    i_redirect = 1'b0;
    total++;
    if (o_inst_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL redirect_ack: got valid=%b req=%b addr=%h, required 0 1 0040",
               o_inst_valid, o_mem_req, o_mem_addr);
    end
    cycle();
    total++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 16'h0040) begin
      bad++;
      $display("FAIL redirect_fetch: got valid=%b pc=%h, required 1 0040", o_inst_valid, o_inst_pc);
    end
  endtask

  task automatic test_wrap();
    i_redirect = 1'b1;
    i_redirect_pc = 16'hFFFF;
    i_inst_ready = 1'b1;
    cycle();
    i_redirect = 1'b0;
    i_inst_ready = 1'b0;
    total++;
    if (o_mem_addr !== 16'hFFFF || o_mem_req !== 1'b1 || o_inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_redirect: got addr=%h req=%b valid=%b, required FFFF 1 0",
               o_mem_addr, o_mem_req, o_inst_valid);
    end
    wait_valid("wrap");
    i_inst_ready = 1'b1;
    cycle();
    i_inst_ready = 1'b0;
    total++;
    if (o_mem_addr !== 16'h0000 || o_mem_req !== 1'b1) begin
      bad++;
      $display("FAIL wrap_pc: got addr=%h req=%b, required 0000 1", o_mem_addr, o_mem_req);
    end
`ifdef FETCH_COUNT_EN
    total++;
    if (o_fetch_count !== exp_count) begin
      bad++;
      $display("FAIL wrap_count: got %0d, required %0d", o_fetch_count, exp_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    wait_valid("mid_pre");
    ack_delay = 5;
    i_inst_ready = 1'b1;
    cycle();
    cycle();
    i_rst = 1'b1;
    cycle();
    total++;
    if ({o_mem_req, o_inst_valid} !== 2'b00 || {o_inst, o_inst_pc, o_mem_addr} !== 48'h0) begin
      bad++;
      $display("FAIL reset_mid: got req=%b valid=%b inst=%h pc=%h addr=%h, required all 0",
               o_mem_req, o_inst_valid, o_inst, o_inst_pc, o_mem_addr);
    end
    i_rst = 1'b0;
    ack_delay = 0;
    i_inst_ready = 1'b0;
    cycle();
    wait_valid("mid_post");
    total++;
    if (o_inst_pc !== 16'h0000 || o_inst !== 16'h8123) begin
      bad++;
      $display("FAIL reset_refetch: got pc=%h inst=%h, required 0000 8123", o_inst_pc, o_inst);
    end
`ifdef FETCH_COUNT_EN
    total++;
    if (o_fetch_count !== exp_count) begin
      bad++;
      $display("FAIL mid_count: got %0d, required %0d", o_fetch_count, exp_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_delay();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
